// File: rtl/mio_pkg.sv
// Shared types and address map for the MEM-stage I/O responder.
// Peripheral decode is only used when MIO_PERIPH_EN is defined.
package mio_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [31:0] PERIPH_BASE = 32'hF000_0000;
   localparam logic [31:0] LED_ADDR    = PERIPH_BASE;
   localparam logic [31:0] CNT_ADDR    = PERIPH_BASE + 32'd4;

   function automatic logic [15:0] merge_led(input logic [15:0] cur,
                                             input logic [15:0] wd,
                                             input logic [1:0]  be);
      merge_led = cur;
      if (be[0]) merge_led[7:0]  = wd[7:0];
      if (be[1]) merge_led[15:8] = wd[15:8];
   endfunction

endpackage

// File: rtl/mio_if.sv
// CPU MEM-stage request/response bundle; the CPU side is master, the responder is slave.
interface mio_if;
   logic        mem_request;
   logic        mem_write;
   logic [31:0] mem_address;
   logic [31:0] mem_writeData;
   logic [3:0]  mem_byteEnable;
   logic        MIO_ready;
   logic [31:0] mem_readData;
   logic        mem_error;

   modport master (
      output mem_request, mem_write, mem_address, mem_writeData, mem_byteEnable,
      input  MIO_ready, mem_readData, mem_error
   );

   modport slave (
      input  mem_request, mem_write, mem_address, mem_writeData, mem_byteEnable,
      output MIO_ready, mem_readData, mem_error
   );
endinterface

// File: rtl/mio_ram.sv
// Single-port data RAM, one byte-wide array per lane so each lane maps onto a plain block RAM.
module mio_ram #(
   parameter int DEPTH = 256,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic          re,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_q;

      always_ff @(posedge clk) begin
         if (we && be[gi]) mem[addr] <= wdata[8*gi +: 8];
         if (re) rd_q <= mem[addr];
      end

      assign rdata[8*gi +: 8] = rd_q;
   end

endmodule

// File: rtl/mio_responder.sv
// Wait-stated memory/IO responder for the CPU MEM stage: data RAM plus optional
// LED and cycle-counter registers (built only when MIO_PERIPH_EN is defined).
module mio_responder
   import mio_pkg::*;
#(
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   mio_if.slave        bus,
   output logic        busy,
   output logic [15:0] led_out
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic        write_q, write_d;
   logic        ready_q, ready_d;
   logic        error_q, error_d;
   logic        use_ram_q, use_ram_d;
   logic [31:0] pdata_q, pdata_d;

   logic        aligned, in_ram, periph_hit, fault, access;
   logic        ram_we, ram_re;
   logic [31:0] ram_rdata, periph_rdata;

   // Decode works on the captured address only; live bus inputs never reach the access path.
   assign aligned = (addr_q[1:0] == 2'b00);
   assign in_ram  = (addr_q[31:AW+2] == '0);
   assign fault   = !aligned || !(in_ram || periph_hit);
   assign access  = (state_q == ST_RESP) && !rst;
   assign ram_we  = access && write_q && in_ram && !fault;
   assign ram_re  = access && !write_q && in_ram && !fault;

`ifdef MIO_PERIPH_EN
   logic        is_led, is_cnt;
   logic [15:0] led_q, led_d;
   logic [31:0] cyc_q, cyc_d;

   assign is_led       = (addr_q == LED_ADDR);
   assign is_cnt       = (addr_q == CNT_ADDR);
   assign periph_hit   = is_led || is_cnt;
   assign periph_rdata = is_led ? {16'b0, led_q} : cyc_q;
   assign led_out      = led_q;

   always_comb begin
      led_d = led_q;
      cyc_d = cyc_q + 32'd1;
      if (access && write_q && is_led) led_d = merge_led(led_q, wdata_q[15:0], be_q[1:0]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         led_q <= '0;
         cyc_q <= '0;
      end else begin
         led_q <= led_d;
         cyc_q <= cyc_d;
      end
   end
`else
   assign periph_hit   = 1'b0;
   assign periph_rdata = '0;
   assign led_out      = '0;
`endif

   mio_ram #(.DEPTH(DEPTH)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .re    (ram_re),
      .be    (be_q),
      .addr  (addr_q[AW+1:2]),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      write_d   = write_q;
      ready_d   = 1'b0;
      error_d   = 1'b0;
      use_ram_d = use_ram_q;
      pdata_d   = pdata_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.mem_request) begin
               addr_d  = bus.mem_address;
               wdata_d = bus.mem_writeData;
               be_d    = bus.mem_byteEnable;
               write_d = bus.mem_write;
               cnt_d   = CNT_INIT;
               state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) state_d = ST_RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         ST_RESP: begin
            state_d   = ST_IDLE;
            ready_d   = 1'b1;
            error_d   = fault;
            // Stores and faults return zero; only successful loads pick a source.
            use_ram_d = !fault && !write_q && in_ram;
            pdata_d   = (!fault && !write_q && !in_ram) ? periph_rdata : 32'd0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
         write_q   <= 1'b0;
         ready_q   <= 1'b0;
         error_q   <= 1'b0;
         use_ram_q <= 1'b0;
         pdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         be_q      <= be_d;
         write_q   <= write_d;
         ready_q   <= ready_d;
         error_q   <= error_d;
         use_ram_q <= use_ram_d;
         pdata_q   <= pdata_d;
      end
   end

   assign bus.MIO_ready    = ready_q;
   assign bus.mem_error    = error_q;
   assign bus.mem_readData = use_ram_q ? ram_rdata : pdata_q;
   assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mio_responder.sv
// Scoreboard bench for mio_responder: a WAIT_CYCLES=2 instance for functional checks and a
// WAIT_CYCLES=0 instance for back-to-back spacing; peripheral checks follow MIO_PERIPH_EN.
module tb_mio_responder;
   import mio_pkg::*;

   typedef struct {
      bit          w;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  be;
      logic [31:0] exp_d;
      bit          exp_err;
      bit          chk_d;
   } op_t;

   typedef struct {
      logic [31:0] d;
      logic        err;
      bit          chk_d;
      int          lat;
   } exp_t;

   localparam int LAT2 = 3;   // WAIT_CYCLES + 1 edges after the sampling edge
   localparam int LAT0 = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        busy, busy0;
   logic [15:0] led_out, led_out0;

   mio_if bus ();
   mio_if bus0 ();

   mio_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .bus(bus), .busy(busy), .led_out(led_out)
   );

   mio_responder #(.DEPTH(16), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0), .busy(busy0), .led_out(led_out0)
   );

   always #5 clk = ~clk;

   int unsigned tb_cyc = 0;
   always @(posedge clk) tb_cyc <= tb_cyc + 1;

   int          n_checks = 0;
   int          n_fail = 0;
   int unsigned ready_cyc = 0;
   exp_t        sb[$];

   // Drives one request, scrambles the inputs while the access is in flight, and
   // returns the observed response with its latency in edges after the sampling edge.
   task automatic issue(input bit sel, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, output logic [31:0] rd, output logic err,
                        output int lat);
      @(negedge clk);
      if (sel) begin
         bus0.mem_write = w; bus0.mem_address = a; bus0.mem_writeData = d;
         bus0.mem_byteEnable = be; bus0.mem_request = 1'b1;
      end else begin
         bus.mem_write = w; bus.mem_address = a; bus.mem_writeData = d;
         bus.mem_byteEnable = be; bus.mem_request = 1'b1;
      end
      lat = -1;
      rd  = '0;
      err = 1'bx;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (k == 0) begin
            if (sel) begin
               bus0.mem_address = $urandom; bus0.mem_writeData = $urandom;
               bus0.mem_byteEnable = 4'($urandom); bus0.mem_write = ~w;
            end else begin
               bus.mem_address = $urandom; bus.mem_writeData = $urandom;
               bus.mem_byteEnable = 4'($urandom); bus.mem_write = ~w;
            end
         end
         if ((sel ? bus0.MIO_ready : bus.MIO_ready) === 1'b1) begin
            lat = k;
            rd  = sel ? bus0.mem_readData : bus.mem_readData;
            err = sel ? bus0.mem_error : bus.mem_error;
            ready_cyc = tb_cyc;
            break;
         end
      end
      bus.mem_request  = 1'b0;
      bus0.mem_request = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus.mem_request = 1'b1; bus.mem_write = 1'b1; bus.mem_address = 32'h10;
      bus.mem_writeData = 32'h1; bus.mem_byteEnable = 4'hF;
      bus0.mem_request = 1'b0; bus0.mem_write = 1'b0; bus0.mem_address = '0;
      bus0.mem_writeData = '0; bus0.mem_byteEnable = '0;
      repeat (3) @(negedge clk);
      n_checks++; if (bus.MIO_ready !== 1'b0) begin n_fail++; $display("FAIL reset ready: got %b want 0", bus.MIO_ready); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
      n_checks++; if (bus.mem_readData !== 32'h0) begin n_fail++; $display("FAIL reset readData: got %h want 0", bus.mem_readData); end
      n_checks++; if (bus.mem_error !== 1'b0) begin n_fail++; $display("FAIL reset error: got %b want 0", bus.mem_error); end
      n_checks++; if (led_out !== 16'h0) begin n_fail++; $display("FAIL reset led_out: got %h want 0", led_out); end
      n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset busy0: got %b want 0", busy0); end
      rst = 1'b0;
      bus.mem_request = 1'b0;
      @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset request_not_captured busy: got %b want 0", busy); end
      $display("reset: done");
   endtask

   task automatic test_store_load;
      op_t ops[$];
      exp_t e;
      logic [31:0] rd; logic err; int lat;
      ops.push_back(op_t'{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 1'b0});
      ops.push_back(op_t'{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 1'b1});
      ops.push_back(op_t'{1'b1, 32'h3FC, 32'h0BADF00D, 4'hF, 32'h0,        1'b0, 1'b0});
      ops.push_back(op_t'{1'b0, 32'h3FC, 32'h0,        4'h0, 32'h0BADF00D, 1'b0, 1'b1});
      ops.push_back(op_t'{1'b1, 32'h0,   32'h01234567, 4'hF, 32'h0,        1'b0, 1'b0});
      ops.push_back(op_t'{1'b0, 32'h0,   32'h0,        4'h0, 32'h01234567, 1'b0, 1'b1});
      foreach (ops[i]) begin
         sb.push_back(exp_t'{ops[i].exp_d, ops[i].exp_err, ops[i].chk_d, LAT2});
         issue(1'b0, ops[i].w, ops[i].a, ops[i].d, ops[i].be, rd, err, lat);
         e = sb.pop_front();
         $display("store_load[%0d]: w=%0b addr=%h rd=%h err=%b lat=%0d", i, ops[i].w, ops[i].a, rd, err, lat);
         n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL store_load[%0d] latency: got %0d want %0d", i, lat, e.lat); end
         n_checks++; if (err !== e.err) begin n_fail++; $display("FAIL store_load[%0d] error: got %b want %b", i, err, e.err); end
         if (e.chk_d) begin
            n_checks++; if (rd !== e.d) begin n_fail++; $display("FAIL store_load[%0d] readData: got %h want %h", i, rd, e.d); end
         end
      end
      @(negedge clk);
      n_checks++; if (bus.MIO_ready !== 1'b0) begin n_fail++; $display("FAIL store_load pulse_width: ready got %b want 0", bus.MIO_ready); end
      n_checks++; if (bus.mem_readData !== 32'h01234567) begin n_fail++; $display("FAIL store_load hold: readData got %h want 01234567", bus.mem_readData); end
   endtask

   task automatic test_byte_enable;
      op_t ops[$];
      exp_t e;
      logic [31:0] rd; logic err; int lat;
      ops.push_back(op_t'{1'b1, 32'h20, 32'hAABBCCDD, 4'b1111, 32'h0,        1'b0, 1'b0});
      ops.push_back(op_t'{1'b1, 32'h20, 32'h11223344, 4'b0101, 32'h0,        1'b0, 1'b0});
      ops.push_back(op_t'{1'b0, 32'h20, 32'h0,        4'b0000, 32'hAA22CC44, 1'b0, 1'b1});
      ops.push_back(op_t'{1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 32'h0,        1'b0, 1'b0});
      ops.push_back(op_t'{1'b0, 32'h20, 32'h0,        4'b0000, 32'hAA22CC44, 1'b0, 1'b1});
      ops.push_back(op_t'{1'b1, 32'h20, 32'h99000000, 4'b1000, 32'h0,        1'b0, 1'b0});
      ops.push_back(op_t'{1'b0, 32'h20, 32'h0,        4'b0000, 32'h9922CC44, 1'b0, 1'b1});
      foreach (ops[i]) begin
         sb.push_back(exp_t'{ops[i].exp_d, ops[i].exp_err, ops[i].chk_d, LAT2});
         issue(1'b0, ops[i].w, ops[i].a, ops[i].d, ops[i].be, rd, err, lat);
         e = sb.pop_front();
         $display("byte_enable[%0d]: w=%0b be=%b rd=%h err=%b lat=%0d", i, ops[i].w, ops[i].be, rd, err, lat);
         n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL byte_enable[%0d] latency: got %0d want %0d", i, lat, e.lat); end
         n_checks++; if (err !== e.err) begin n_fail++; $display("FAIL byte_enable[%0d] error: got %b want %b", i, err, e.err); end
         if (e.chk_d) begin
            n_checks++; if (rd !== e.d) begin n_fail++; $display("FAIL byte_enable[%0d] readData: got %h want %h", i, rd, e.d); end
         end
      end
   endtask

   task automatic test_faults;
      op_t ops[$];
      exp_t e;
      logic [31:0] rd; logic err; int lat;
      ops.push_back(op_t'{1'b0, 32'h13,        32'h0,        4'h0, 32'h0,        1'b1, 1'b1});
      ops.push_back(op_t'{1'b0, 32'h400,       32'h0,        4'h0, 32'h0,        1'b1, 1'b1});
      ops.push_back(op_t'{1'b0, 32'h8000_0000, 32'h0,        4'h0, 32'h0,        1'b1, 1'b1});
      ops.push_back(op_t'{1'b1, 32'h12,        32'hFFFFFFFF, 4'hF, 32'h0,        1'b1, 1'b0});
      ops.push_back(op_t'{1'b1, 32'h400,       32'hFFFFFFFF, 4'hF, 32'h0,        1'b1, 1'b0});
      ops.push_back(op_t'{1'b0, 32'h10,        32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 1'b1});
      ops.push_back(op_t'{1'b0, 32'h0,         32'h0,        4'h0, 32'h01234567, 1'b0, 1'b1});
      foreach (ops[i]) begin
         sb.push_back(exp_t'{ops[i].exp_d, ops[i].exp_err, ops[i].chk_d, LAT2});
         issue(1'b0, ops[i].w, ops[i].a, ops[i].d, ops[i].be, rd, err, lat);
         e = sb.pop_front();
         $display("faults[%0d]: w=%0b addr=%h rd=%h err=%b lat=%0d", i, ops[i].w, ops[i].a, rd, err, lat);
         n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL faults[%0d] latency: got %0d want %0d", i, lat, e.lat); end
         n_checks++; if (err !== e.err) begin n_fail++; $display("FAIL faults[%0d] error: got %b want %b", i, err, e.err); end
         if (e.chk_d) begin
            n_checks++; if (rd !== e.d) begin n_fail++; $display("FAIL faults[%0d] readData: got %h want %h", i, rd, e.d); end
         end
      end
   endtask

   task automatic test_abort;
      logic [31:0] rd; logic err; int lat;
      issue(1'b0, 1'b1, 32'h30, 32'h5555AAAA, 4'hF, rd, err, lat);
      for (int k = 1; k <= 3; k += 2) begin
         @(negedge clk);
         bus.mem_write = 1'b1; bus.mem_address = 32'h30;
         bus.mem_writeData = 32'h12345678; bus.mem_byteEnable = 4'hF; bus.mem_request = 1'b1;
         @(negedge clk);
         for (int j = 0; j < k; j++) begin
            n_checks++; if (bus.MIO_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL abort k=%0d pre j=%0d: ready=%b busy=%b want ready 0 busy 1", k, j, bus.MIO_ready, busy); end
            if (j < k - 1) @(negedge clk);
         end
         rst = 1'b1;
         bus.mem_request = 1'b0;
         @(negedge clk);
         rst = 1'b0;
         n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort k=%0d busy: got %b want 0", k, busy); end
         for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            n_checks++; if (bus.MIO_ready !== 1'b0) begin n_fail++; $display("FAIL abort k=%0d spurious ready at cycle %0d: got %b want 0", k, j, bus.MIO_ready); end
         end
         sb.push_back(exp_t'{32'h5555AAAA, 1'b0, 1'b1, LAT2});
         issue(1'b0, 1'b0, 32'h30, 32'h0, 4'h0, rd, err, lat);
         begin
            exp_t e;
            e = sb.pop_front();
            $display("abort k=%0d: reload 0x30 rd=%h err=%b lat=%0d", k, rd, err, lat);
            n_checks++; if (rd !== e.d || err !== e.err || lat !== e.lat) begin n_fail++; $display("FAIL abort k=%0d reload: got rd=%h err=%b lat=%0d want rd=%h err=%b lat=%0d", k, rd, err, lat, e.d, e.err, e.lat); end
         end
      end
   endtask

   task automatic test_periph;
      logic [31:0] rd; logic err; int lat;
`ifdef MIO_PERIPH_EN
      logic [31:0] c1;
      int unsigned t1;
      issue(1'b0, 1'b1, LED_ADDR, 32'h0000ABCD, 4'b0011, rd, err, lat);
      $display("periph: store led err=%b led_out=%h", err, led_out);
      n_checks++; if (err !== 1'b0 || lat !== LAT2) begin n_fail++; $display("FAIL periph led_store: err=%b lat=%0d want err 0 lat %0d", err, lat, LAT2); end
      n_checks++; if (led_out !== 16'hABCD) begin n_fail++; $display("FAIL periph led_out: got %h want abcd", led_out); end
      issue(1'b0, 1'b1, LED_ADDR, 32'hFFFF1234, 4'b0010, rd, err, lat);
      n_checks++; if (led_out !== 16'h12CD) begin n_fail++; $display("FAIL periph led_be: got %h want 12cd", led_out); end
      issue(1'b0, 1'b0, LED_ADDR, 32'h0, 4'h0, rd, err, lat);
      n_checks++; if (rd !== 32'h000012CD || err !== 1'b0) begin n_fail++; $display("FAIL periph led_load: got %h err=%b want 000012cd err 0", rd, err); end
      issue(1'b0, 1'b0, CNT_ADDR, 32'h0, 4'h0, rd, err, lat);
      c1 = rd; t1 = ready_cyc;
      repeat (3) @(negedge clk);
      issue(1'b0, 1'b0, CNT_ADDR, 32'h0, 4'h0, rd, err, lat);
      $display("periph: counter c1=%0d c2=%0d cycles=%0d", c1, rd, ready_cyc - t1);
      n_checks++; if (rd - c1 !== ready_cyc - t1 || err !== 1'b0) begin n_fail++; $display("FAIL periph counter delta: got %0d err=%b want %0d err 0", rd - c1, err, ready_cyc - t1); end
      issue(1'b0, 1'b1, CNT_ADDR, 32'h0, 4'hF, rd, err, lat);
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL periph counter_store error: got %b want 0", err); end
`else
      issue(1'b0, 1'b1, LED_ADDR, 32'h0000ABCD, 4'b0011, rd, err, lat);
      $display("periph(off): store led err=%b led_out=%h", err, led_out);
      n_checks++; if (err !== 1'b1 || lat !== LAT2) begin n_fail++; $display("FAIL periph_off led_store: err=%b lat=%0d want err 1 lat %0d", err, lat, LAT2); end
      n_checks++; if (led_out !== 16'h0) begin n_fail++; $display("FAIL periph_off led_out: got %h want 0", led_out); end
      issue(1'b0, 1'b0, CNT_ADDR, 32'h0, 4'h0, rd, err, lat);
      n_checks++; if (err !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL periph_off counter_load: rd=%h err=%b want 0 err 1", rd, err); end
`endif
   endtask

   task automatic test_back_to_back;
      logic [31:0] rd; logic err; int lat;
      @(negedge clk);
      bus0.mem_write = 1'b1; bus0.mem_address = 32'h8;
      bus0.mem_writeData = 32'hCAFE0000; bus0.mem_byteEnable = 4'hF; bus0.mem_request = 1'b1;
      for (int j = 0; j < 12; j++) begin
         @(negedge clk);
         $display("back_to_back[%0d]: ready=%b busy=%b", j, bus0.MIO_ready, busy0);
         n_checks++; if (bus0.MIO_ready !== 1'((j % 2) == 1)) begin n_fail++; $display("FAIL back_to_back[%0d] ready: got %b want %b", j, bus0.MIO_ready, (j % 2) == 1); end
         n_checks++; if (busy0 !== 1'((j % 2) == 0)) begin n_fail++; $display("FAIL back_to_back[%0d] busy: got %b want %b", j, busy0, (j % 2) == 0); end
      end
      bus0.mem_request = 1'b0;
      sb.push_back(exp_t'{32'hCAFE0000, 1'b0, 1'b1, LAT0});
      issue(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, rd, err, lat);
      begin
         exp_t e;
         e = sb.pop_front();
         $display("back_to_back: load 0x8 rd=%h err=%b lat=%0d", rd, err, lat);
         n_checks++; if (rd !== e.d || err !== e.err || lat !== e.lat) begin n_fail++; $display("FAIL back_to_back load: got rd=%h err=%b lat=%0d want rd=%h err=%b lat=%0d", rd, err, lat, e.d, e.err, e.lat); end
      end
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_byte_enable();
      test_faults();
      test_abort();
      test_periph();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at time %0t, limit 200000", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
